// File: rtl/pipe_pkg.sv
// Shared constants for the fetch/decode pipeline register: payload width,
// default stall-counter width and the occupancy state encoding.
package pipe_pkg;

    localparam int IF_ID_DATA_W  = 75;
    localparam int DEFAULT_CNT_W = 16;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
        if (skid_v)
            return OCC_FULL;
        else if (main_v)
            return OCC_ONE;
        else
            return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus payload register with clear, load and
// drop. Payload is zeroed whenever the slot goes empty so nothing stale leaks.
module pipe_entry #(
    parameter int DATA_W = 75
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
            q     <= '0;
        end
    end

endmodule

// File: rtl/skid_pipe_reg.sv
// Valid/ready pipeline register with stall counter. Define SKID_PIPE_SKID_EN
// for the two-entry build whose in_ready comes straight from a flop.
//
// Handshake: a beat moves on an edge where valid=1, ready=1 and flush=0;
// the producer holds valid and data steady until that edge.
module skid_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IF_ID_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occ_state
);

    logic              accept;
    logic              consume;
    logic              clr;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_drop;
    logic [DATA_W-1:0] main_d;

    assign clr       = rst | flush;
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = main_valid & out_ready & ~flush;
    assign out_valid = main_valid;
    assign out_data  = main_data;

`ifdef SKID_PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_drop;
    logic              skid_nxt;
    logic              ready_q;

    // Skid entry always advances into main first, so order is preserved.
    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        main_d    = in_data;
        if (skid_valid && consume) begin
            main_load = 1'b1;
            main_d    = skid_data;
            skid_drop = 1'b1;
        end else if (accept && (!main_valid || consume)) begin
            main_load = 1'b1;
        end else if (accept) begin
            skid_load = 1'b1;
        end else if (consume) begin
            main_drop = 1'b1;
        end
    end

    assign skid_nxt = ~flush & (skid_load | (skid_valid & ~skid_drop));

    always_ff @(posedge clk) begin
        if (rst)
            ready_q <= 1'b1;
        else
            ready_q <= ~skid_nxt;
    end

    assign in_ready = ready_q & ~rst;

    pipe_entry #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .clr   (clr),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_data)
    );

    assign occ_state = occ_encode(main_valid, skid_valid);
`else
    assign main_load = accept;
    assign main_drop = consume & ~accept;
    assign main_d    = in_data;
    assign in_ready  = ~rst & (~main_valid | out_ready);
    assign occ_state = occ_encode(main_valid, 1'b0);
`endif

    pipe_entry #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .clr   (clr),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_data)
    );

    // The flush cycle is not counted as a stall: its entry is being discarded.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && !flush && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
